cplx_dot_accum: RTL and testbench

- Downstream consumer of the complex multiplier: takes a stream of complex products (re, im, ovr) and accumulates LEN of them into one complex dot-product term. One use is one row of a gate matrix times a state-vector slice.
- Data format matches the multiplier/adder library: N-bit sign-magnitude, MSB is sign, N-1 fractional bits (Q = N-1).
- Valid/ready handshake on both the input and output sides.
- Result is saturated back to N-bit sign-magnitude, with a sticky overflow flag.

---
 rtl/cplx_fixed_pkg.sv | 47 ++++
 rtl/cplx_dot_accum_conv.sv | 26 ++
 rtl/cplx_dot_accum.sv | 103 ++++++++++
 tb/tb_cplx_dot_accum.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cplx_fixed_pkg.sv
// cplx_fixed_pkg
// Shared fixed-point helpers for the complex multiplier/adder/accumulator
// family. Data is N-bit sign-magnitude with N-1 fractional bits.
//   N_DEF        : default data width
//   acc_w()      : accumulator width for summing LEN full-scale samples
//   sm_to_tc()   : sign-magnitude -> two's complement (negative zero -> 0)
//   tc_to_sm_sat(): two's complement -> saturated sign-magnitude, {sat, sm}
// The helpers work on MAX_W-bit containers so one function serves every width.
package cplx_fixed_pkg;

  localparam int N_DEF = 16;
  localparam int MAX_W = 64;

  typedef struct packed {
    logic             sat;
    logic [MAX_W-1:0] sm;
  } sm_sat_t;

  // One extra guard bit beyond clog2(len) covers the sign growth of |sum|.
  function automatic int acc_w(input int n, input int len);
    return n + $clog2(len) + 1;
  endfunction

  function automatic logic signed [MAX_W-1:0] sm_to_tc(input logic [MAX_W-1:0] sm,
                                                       input int width);
    logic [MAX_W-1:0] mag;
    mag = sm & ((64'd1 << (width - 1)) - 64'd1);
    return sm[width-1] ? -$signed(mag) : $signed(mag);
  endfunction

  function automatic sm_sat_t tc_to_sm_sat(input logic signed [MAX_W-1:0] tc,
                                           input int n);
    logic             neg;
    logic [MAX_W-1:0] mag;
    logic [MAX_W-1:0] max_mag;
    sm_sat_t          r;
    neg     = tc < 0;
    mag     = neg ? $unsigned(-tc) : $unsigned(tc);
    max_mag = (64'd1 << (n - 1)) - 64'd1;
    r.sat   = mag > max_mag;
    // neg implies mag != 0, so negative zero can never be produced here.
    if (r.sat) r.sm = ({{(MAX_W-1){1'b0}}, neg} << (n - 1)) | max_mag;
    else       r.sm = ({{(MAX_W-1){1'b0}}, neg} << (n - 1)) | mag;
    return r;
  endfunction

endpackage

// File: rtl/cplx_dot_accum_conv.sv
// sm_sat_conv
// Combinational two's-complement to N-bit sign-magnitude converter with
// saturation to full-scale magnitude.
//   tc  : signed accumulator value, ACC_W bits
//   sm  : sign-magnitude result, N bits
//   sat : |tc| exceeded 2^(N-1)-1
module sm_sat_conv
  import cplx_fixed_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int ACC_W = N + 3
) (
  input  logic signed [ACC_W-1:0] tc,
  output logic        [N-1:0]     sm,
  output logic                    sat
);

  sm_sat_t r;
  logic    unused_hi;

  assign r         = tc_to_sm_sat(MAX_W'(tc), N);
  assign sm        = r.sm[N-1:0];
  assign sat       = r.sat;
  assign unused_hi = ^r.sm[MAX_W-1:N];

endmodule

// File: rtl/cplx_dot_accum.sv
// cplx_dot_accum
// Accumulates LEN complex sign-magnitude products into one saturated
// complex dot-product term with a sticky overflow flag.
//   clk, rst                      : clock, async active-high reset
//   in_valid/in_ready             : input handshake
//   in_re, in_im, in_ovr          : product sample and its overflow flag
//   out_valid/out_ready           : output handshake
//   out_re, out_im, out_ovr       : held result until accepted
// States: ACC accepts samples; DONE holds the result, input stalled.
module cplx_dot_accum
  import cplx_fixed_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int LEN = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_re,
  input  logic [N-1:0] in_im,
  input  logic         in_ovr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_re,
  output logic [N-1:0] out_im,
  output logic         out_ovr
);

  localparam int ACC_W = acc_w(N, LEN);
  localparam int CNT_W = $clog2(LEN);

  typedef enum logic {ACC, DONE} state_t;

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic signed [ACC_W-1:0]  acc_re, acc_im;
  logic signed [ACC_W-1:0]  smp_re, smp_im;
  logic signed [ACC_W-1:0]  sum_re, sum_im;
  logic                     ovr_acc;
  logic [N-1:0]             cv_re, cv_im;
  logic                     sat_re, sat_im;
  logic                     accept, last;

  assign smp_re = ACC_W'(sm_to_tc(MAX_W'(in_re), N));
  assign smp_im = ACC_W'(sm_to_tc(MAX_W'(in_im), N));
  assign sum_re = acc_re + smp_re;
  assign sum_im = acc_im + smp_im;
  assign accept = in_valid & in_ready;
  assign last   = cnt == CNT_W'(LEN - 1);

  // Converters see acc+sample so the final sample lands in the result.
  sm_sat_conv #(.N(N), .ACC_W(ACC_W)) u_conv_re (.tc(sum_re), .sm(cv_re), .sat(sat_re));
  sm_sat_conv #(.N(N), .ACC_W(ACC_W)) u_conv_im (.tc(sum_im), .sm(cv_im), .sat(sat_im));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACC;
      cnt       <= '0;
      acc_re    <= '0;
      acc_im    <= '0;
      ovr_acc   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_ovr   <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            if (last) begin
              out_re    <= cv_re;
              out_im    <= cv_im;
              out_ovr   <= ovr_acc | in_ovr | sat_re | sat_im;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
              acc_re    <= '0;
              acc_im    <= '0;
              ovr_acc   <= 1'b0;
              cnt       <= '0;
              state     <= DONE;
            end else begin
              acc_re  <= sum_re;
              acc_im  <= sum_im;
              ovr_acc <= ovr_acc | in_ovr;
              cnt     <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_cplx_dot_accum.sv
module tb_cplx_dot_accum;

  localparam int N   = 16;
  localparam int LEN = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_re, in_im;
  logic         in_ovr;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_re, out_im;
  logic         out_ovr;

  typedef struct packed {
    logic [N-1:0] re;
    logic [N-1:0] im;
    logic         ovr;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  int   m_re, m_im, m_cnt;
  bit   m_ovr;

  always #5 clk = ~clk;

  cplx_dot_accum #(.N(N), .LEN(LEN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .in_ovr(in_ovr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_ovr(out_ovr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic int sm2int(input logic [N-1:0] v);
    int mag;
    mag = int'(v[N-2:0]);
    return v[N-1] ? -mag : mag;
  endfunction

  // Returns {sat, sign-magnitude}
  function automatic logic [N:0] enc(input int v);
    int mag;
    logic [N-2:0] mbits;
    mag = (v < 0) ? -v : v;
    if (mag > (1 << (N-1)) - 1) return {1'b1, (v < 0), {(N-1){1'b1}}};
    mbits = mag[N-2:0];
    return {1'b0, (v < 0), mbits};
  endfunction

  task automatic model_clear();
    m_re = 0; m_im = 0; m_cnt = 0; m_ovr = 0;
  endtask

  task automatic model_add(input logic [N-1:0] re, input logic [N-1:0] im, input logic ovr);
    logic [N:0] er, ei;
    exp_t e;
    m_re  += sm2int(re);
    m_im  += sm2int(im);
    m_ovr |= ovr;
    m_cnt++;
    if (m_cnt == LEN) begin
      er = enc(m_re);
      ei = enc(m_im);
      e.re  = er[N-1:0];
      e.im  = ei[N-1:0];
      e.ovr = m_ovr | er[N] | ei[N];
      exp_q.push_back(e);
      model_clear();
    end
  endtask

  // Called and returns at a negedge.
  task automatic send(input logic [N-1:0] re, input logic [N-1:0] im, input logic ovr);
    int waits = 0;
    bit done = 0;
    in_valid = 1'b1; in_re = re; in_im = im; in_ovr = ovr;
    while (!done) begin
      if (in_ready === 1'b1) done = 1;
      @(posedge clk);
      @(negedge clk);
      if (!done) begin
        waits++;
        if (waits > 50) begin
          check("send_timeout", 32'd0, 32'd1);
          break;
        end
      end
    end
    in_valid = 1'b0;
    if (done) model_add(re, im, ovr);
  endtask

  // Entered at the negedge right after the LENth accept.
  task automatic expect_result(input string tag);
    int   waits = 0;
    exp_t e;
    check({tag, "_latency"}, 32'(out_valid), 32'd1);
    while (out_valid !== 1'b1 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (out_valid !== 1'b1) begin
      check({tag, "_timeout"}, 32'(out_valid), 32'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_re"},  32'(out_re),  32'(e.re));
    check({tag, "_im"},  32'(out_im),  32'(e.im));
    check({tag, "_ovr"}, 32'(out_ovr), 32'(e.ovr));
    if (out_ready === 1'b1) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
      check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    exp_t front;
    rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0; in_ovr = 1'b0; out_ready = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_re",    32'(out_re),    32'd0);
    check("rst_out_im",    32'(out_im),    32'd0);
    check("rst_out_ovr",   32'(out_ovr),   32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic sum
    for (int i = 0; i < LEN; i++) send(16'h1000, 16'h0000, 1'b0);
    expect_result("basic");

    // Mixed signs with negative zero, and idle gaps between samples
    send(16'h4000, 16'h9000, 1'b0);
    repeat (2) @(negedge clk);
    send(16'hC000, 16'h9000, 1'b0);
    send(16'h2000, 16'h9000, 1'b0);
    repeat (3) @(negedge clk);
    send(16'h8000, 16'h9000, 1'b0);
    expect_result("mixed");

    // Saturation in both directions
    for (int i = 0; i < LEN; i++) send(16'h2000, 16'hA000, 1'b0);
    expect_result("sat");

    // Back-pressure: result held, input stalled while a sample is offered
    out_ready = 1'b0;
    for (int i = 0; i < LEN; i++) send(16'h0800, 16'h8400, 1'b0);
    check("bp_valid", 32'(out_valid), 32'd1);
    front = (exp_q.size() != 0) ? exp_q[0] : '0;
    in_valid = 1'b1; in_re = 16'h7FFF; in_im = 16'h7FFF; in_ovr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready",   32'(in_ready),  32'd0);
      check("bp_hold_re",    32'(out_re),    32'(front.re));
      check("bp_hold_im",    32'(out_im),    32'(front.im));
    end
    in_valid = 1'b0; in_ovr = 1'b0;
    out_ready = 1'b1;
    expect_result("bp");
    for (int i = 0; i < LEN; i++) send(16'h0100, 16'h0000, 1'b0);
    expect_result("bp_next");

    // Sticky overflow flag, then cleared for the following product
    for (int i = 0; i < LEN; i++) send(16'h1000, 16'h0000, (i == 1));
    expect_result("sticky");
    for (int i = 0; i < LEN; i++) send(16'h1000, 16'h0000, 1'b0);
    expect_result("sticky_clear");

    // Reset mid-stream discards the partial sum
    send(16'h4000, 16'h0000, 1'b0);
    send(16'h4000, 16'h0000, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ready", 32'(in_ready),  32'd1);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < LEN; i++) send(16'h1000, 16'h0000, 1'b0);
    expect_result("after_rst");

    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
